// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: line/word types, FSM state encoding and grant policy.
// Define ARB_RR_EN to switch simultaneous-request arbitration from fixed data priority to round-robin.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } lc3b_arb_state;

`ifdef ARB_RR_EN
  localparam bit ARB_RR = 1'b1;
`else
  localparam bit ARB_RR = 1'b0;
`endif

  // Returns 1 when the data cache should win this grant. last_grant: 0 = I, 1 = D.
  function automatic logic pick_data(input logic i_req, input logic d_req,
                                     input logic last_grant);
    logic rr_pick;
    rr_pick = d_req && (!i_req || !last_grant);
    return ARB_RR ? rr_pick : d_req;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory signals around the arbiter.
// slave = arbiter view; master = requesters plus memory model view.
interface cache_arbiter_if;
  import lc3b_types::*;

  logic      i_read;
  lc3b_word  i_address;
  cache_line i_rdata;
  logic      i_resp;

  logic      d_read;
  logic      d_write;
  lc3b_word  d_address;
  cache_line d_wdata;
  cache_line d_rdata;
  logic      d_resp;

  logic      pmem_read;
  logic      pmem_write;
  lc3b_word  pmem_address;
  cache_line pmem_wdata;
  cache_line pmem_rdata;
  logic      pmem_resp;

  logic      last_grant;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata, last_grant
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata, last_grant
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: grants one cache at a time to physical memory, then inserts a RELEASE cycle.
// Grant policy follows ARB_RR_EN through lc3b_types::pick_data.
module cache_arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_read,
  input  logic d_read,
  input  logic d_write,
  input  logic pmem_resp,
  output logic serve_i,
  output logic serve_d,
  output logic pmem_read,
  output logic pmem_write,
  output logic i_resp,
  output logic d_resp,
  output logic last_grant
);

  lc3b_arb_state state, state_next;
  logic          d_req;
  logic          grant_d;

  assign d_req   = d_read | d_write;
  assign grant_d = pick_data(i_read, d_req, last_grant);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (i_read || d_req))
        last_grant <= grant_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    serve_i    = 1'b0;
    serve_d    = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_read || d_req)
          state_next = grant_d ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        serve_i   = 1'b1;
        pmem_read = i_read;
        i_resp    = pmem_resp;
        if (pmem_resp)
          state_next = RELEASE;
      end
      SERVE_D: begin
        // Writeback takes precedence when both data strobes are high.
        serve_d    = 1'b1;
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        d_resp     = pmem_resp;
        if (pmem_resp)
          state_next = RELEASE;
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port cache arbiter top: FSM lives in cache_arbiter_control; this level only muxes address/data.
// Optional round-robin arbitration with ARB_RR_EN.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  bus
);

  logic serve_i;
  logic serve_d;

  cache_arbiter_control u_control (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (bus.i_read),
    .d_read     (bus.d_read),
    .d_write    (bus.d_write),
    .pmem_resp  (bus.pmem_resp),
    .serve_i    (serve_i),
    .serve_d    (serve_d),
    .pmem_read  (bus.pmem_read),
    .pmem_write (bus.pmem_write),
    .i_resp     (bus.i_resp),
    .d_resp     (bus.d_resp),
    .last_grant (bus.last_grant)
  );

  // Address and write data are zero whenever no cache owns the memory port.
  assign bus.pmem_address = serve_i ? bus.i_address :
                            serve_d ? bus.d_address : '0;
  assign bus.pmem_wdata   = serve_d ? bus.d_wdata : '0;

  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule
